wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic for the 5-stage MIPS pipeline.
- Sits directly upstream of the register file and drives its write port: WrEn, Rw, busW, R31Wr and R31.
- Selects the write-back value from the ALU result, extended load data, or the link address.
- Registered outputs also serve as the MEM/WB forwarding source for the EX stage.

Parameters:
- DW, 32, datapath width (fixed at 32; listed for lint only).
- AW, 5, register index width.

Ports:
- Clk  in  1  pipeline clock; registers update on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hold the MEM/WB register contents.
- Flush  in  1  load a bubble (valid=0).
- mem_Valid  in  1  MEM-stage instruction is real.
- mem_RegWr  in  1  instruction writes GPR Rw.
- mem_Rw  in  5  destination register.
- mem_MemtoReg  in  1  1: load data, 0: ALU result.
- mem_LoadType  in  3  load width/sign, encoded per the package.
- mem_AluOut  in  32  ALU result / effective address.
- mem_DmOut  in  32  raw data-memory word.
- mem_Link  in  1  jal/jalr link write to R31.
- mem_PC4  in  30  PC+4 word address [31:2].
- WrEn  out  1  register-file write enable.
- Rw  out  5  register-file write index.
- busW  out  32  register-file write data.
- R31Wr  out  1  link write enable.
- R31  out  30  link address [31:2].
- wb_Valid  out  1  WB stage holds a real instruction.

Behaviour:
- Reset (Rst_n=0, async): all internal registers clear to 0, so WrEn=0, Rw=0, busW=0, R31Wr=0, R31=0, wb_Valid=0. Assertion mid-cycle clears outputs immediately. No write may reach the register file while Rst_n=0.
- Posedge priority: Flush > Stall > load.
  - Flush: valid=0, all controls 0. Data fields are don't-care but cleared to 0.
  - Stall: all fields hold.
  - Otherwise: capture every mem_* input.
- Latency:
  - Inputs sampled at posedge N appear on outputs after posedge N.
  - The register file commits at the following negedge, so a same-cycle ID read sees the new value.
- Load extension, computed combinationally from the registered AluOut[1:0] and DmOut, big-endian:
  - LB/LBU: offset 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. Sign- or zero-extend to 32.
  - LH/LHU: AluOut[1]=0→[31:16], 1→[15:0]. AluOut[0] is ignored.
  - LW and reserved encodings (5-7): the full word. AluOut[1:0] is ignored.
- busW = MemtoReg ? extended load data : AluOut.
- WrEn = valid & RegWr & (Rw≠0) & ~(Link & Rw==31). R0 is never written.
- R31Wr = valid & Link.
- R31 = registered PC4.
- Conflict rule: when Link and RegWr both target R31 in the same instruction, the link write wins and the GPR write is suppressed.
- Rw output = registered Rw, even when WrEn=0.
- Stall held across many cycles: outputs are stable and WrEn stays asserted. The write repeats identically each negedge, which is harmless and required.

Decomposition:
- Shared package mips_pkg holds:
  - LoadType constants: LT_LW=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4.
  - REG_LINK=31.
  - A struct/typedef for the MEM/WB control bundle {valid, RegWr, MemtoReg, Link, LoadType}.
- Sub-module load_ext: purely combinational extraction/extension with inputs DmOut, addr[1:0], LoadType and output 32-bit data.
- wb_stage contains the register, the priority logic and the write-back mux.

Test Plan:
- Reset: Rst_n=0 mid-cycle with valid inputs → all outputs 0 immediately. Release, load ALU write Rw=8, AluOut=0x5 → WrEn=1, Rw=8, busW=0x00000005 after the next posedge.
- Loads, DmOut=0x80FF7F01:
  - LB @ offset 0 → 0xFFFFFF80.
  - LBU @ offset 0 → 0x00000080.
  - LB @ offset 2 → 0x0000007F.
  - LH @ addr[1]=1 → 0x00007F01.
  - LHU @ addr[1]=0 → 0x000080FF.
  - LW → 0x80FF7F01.
- Link: Link=1, PC4=0x00000C01, RegWr=1, Rw=31 → R31Wr=1, R31=0x00000C01, WrEn=0.
- R0 guard: RegWr=1, Rw=0, AluOut=0xDEADBEEF → WrEn=0.
- Stall/flush: load Rw=9/0x1234, then Stall=1 for 3 cycles with new inputs → outputs hold 9/0x1234. Stall=1 with Flush=1 → wb_Valid=0, WrEn=0, R31Wr=0 next cycle.
- Bubble: mem_Valid=0 with RegWr=1, Link=1 → WrEn=0, R31Wr=0, wb_Valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load-type encodings, link register index, MEM/WB control bundle.
// Pure declarations; no timing or backpressure.
package mips_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  localparam logic [AW-1:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic       valid;
    logic       reg_wr;
    logic       memto_reg;
    logic       link;
    logic [2:0] load_type;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage inputs and register-file write-port outputs of the MEM/WB stage.
// master drives the MEM side; slave is the write-back stage itself.
interface wb_stage_if;
  import mips_pkg::*;

  logic          mem_Valid;
  logic          mem_RegWr;
  logic [AW-1:0] mem_Rw;
  logic          mem_MemtoReg;
  logic [2:0]    mem_LoadType;
  logic [DW-1:0] mem_AluOut;
  logic [DW-1:0] mem_DmOut;
  logic          mem_Link;
  logic [29:0]   mem_PC4;

  logic          WrEn;
  logic [AW-1:0] Rw;
  logic [DW-1:0] busW;
  logic          R31Wr;
  logic [29:0]   R31;
  logic          wb_Valid;

  modport master (
    output mem_Valid, mem_RegWr, mem_Rw, mem_MemtoReg, mem_LoadType,
           mem_AluOut, mem_DmOut, mem_Link, mem_PC4,
    input  WrEn, Rw, busW, R31Wr, R31, wb_Valid
  );

  modport slave (
    input  mem_Valid, mem_RegWr, mem_Rw, mem_MemtoReg, mem_LoadType,
           mem_AluOut, mem_DmOut, mem_Link, mem_PC4,
    output WrEn, Rw, busW, R31Wr, R31, wb_Valid
  );

endinterface

// File: rtl/load_ext.sv
// Big-endian byte/halfword extraction with sign/zero extension of a data-memory word.
// Combinational, zero latency; no backpressure.
module load_ext
  import mips_pkg::*;
(
  input  logic [DW-1:0] dm_i,
  input  logic [1:0]    addr_i,
  input  logic [2:0]    load_type_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = dm_i[31:24];
      2'd1:    byte_sel = dm_i[23:16];
      2'd2:    byte_sel = dm_i[15:8];
      default: byte_sel = dm_i[7:0];
    endcase
    half_sel = addr_i[1] ? dm_i[15:0] : dm_i[31:16];
  end

  // Reserved encodings fall through to a full-word load.
  always_comb begin
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'd0, byte_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data_o = {16'd0, half_sel};
      default: data_o = dm_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back mux driving the register-file write port.
// One cycle from mem_* to outputs; Flush inserts a bubble, Stall holds (Flush wins).
module wb_stage
  import mips_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int AW_P = AW
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Stall,
  input  logic Flush,
  wb_stage_if.slave bus
);

  wb_ctrl_t        ctrl_q, ctrl_d;
  logic [AW_P-1:0] rw_q, rw_d;
  logic [DW_P-1:0] alu_q, alu_d;
  logic [DW_P-1:0] dm_q, dm_d;
  logic [29:0]     pc4_q, pc4_d;
  logic [DW_P-1:0] load_data;

  always_comb begin
    ctrl_d = ctrl_q;
    rw_d   = rw_q;
    alu_d  = alu_q;
    dm_d   = dm_q;
    pc4_d  = pc4_q;
    if (Flush) begin
      ctrl_d = '0;
      rw_d   = '0;
      alu_d  = '0;
      dm_d   = '0;
      pc4_d  = '0;
    end else if (!Stall) begin
      ctrl_d.valid     = bus.mem_Valid;
      ctrl_d.reg_wr    = bus.mem_RegWr;
      ctrl_d.memto_reg = bus.mem_MemtoReg;
      ctrl_d.link      = bus.mem_Link;
      ctrl_d.load_type = bus.mem_LoadType;
      rw_d             = bus.mem_Rw;
      alu_d            = bus.mem_AluOut;
      dm_d             = bus.mem_DmOut;
      pc4_d            = bus.mem_PC4;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_q <= '0;
      rw_q   <= '0;
      alu_q  <= '0;
      dm_q   <= '0;
      pc4_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rw_q   <= rw_d;
      alu_q  <= alu_d;
      dm_q   <= dm_d;
      pc4_q  <= pc4_d;
    end
  end

  load_ext u_load_ext (
    .dm_i        (dm_q),
    .addr_i      (alu_q[1:0]),
    .load_type_i (ctrl_q.load_type),
    .data_o      (load_data)
  );

  // A link to R31 overrides a simultaneous GPR write of R31; R0 is never written.
  assign bus.WrEn     = ctrl_q.valid & ctrl_q.reg_wr & (rw_q != '0)
                        & ~(ctrl_q.link & (rw_q == REG_LINK));
  assign bus.Rw       = rw_q;
  assign bus.busW     = ctrl_q.memto_reg ? load_data : alu_q;
  assign bus.R31Wr    = ctrl_q.valid & ctrl_q.link;
  assign bus.R31      = pc4_q;
  assign bus.wb_Valid = ctrl_q.valid;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;
  import mips_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n, Stall, Flush;
  int checks = 0;
  int errors = 0;

  wb_stage_if bus ();

  wb_stage dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Stall (Stall),
    .Flush (Flush),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rwr, input logic [4:0] rw,
                       input logic m2r, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] dm, input logic lnk, input logic [29:0] pc4);
    bus.mem_Valid    = v;
    bus.mem_RegWr    = rwr;
    bus.mem_Rw       = rw;
    bus.mem_MemtoReg = m2r;
    bus.mem_LoadType = lt;
    bus.mem_AluOut   = alu;
    bus.mem_DmOut    = dm;
    bus.mem_Link     = lnk;
    bus.mem_PC4      = pc4;
  endtask

  task automatic load_check(input string tag, input logic [2:0] lt,
                            input logic [31:0] addr, input logic [31:0] exp);
    drive(1, 1, 5'd3, 1, lt, addr, 32'h80FF7F01, 0, 30'd0);
    tick();
    check(tag, bus.busW, exp);
  endtask

  initial begin
    Rst_n = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    drive(1, 1, 5'd7, 0, LT_LW, 32'h11, 32'h0, 1, 30'h155);
    #2;
    check("rst_wren", {31'd0, bus.WrEn}, 32'd0);
    check("rst_valid", {31'd0, bus.wb_Valid}, 32'd0);

    // Load a real instruction, then assert reset mid-cycle.
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    check("pre_rst_wren", {31'd0, bus.WrEn}, 32'd1);
    check("pre_rst_r31wr", {31'd0, bus.R31Wr}, 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_wren", {31'd0, bus.WrEn}, 32'd0);
    check("midrst_rw", {27'd0, bus.Rw}, 32'd0);
    check("midrst_busw", bus.busW, 32'd0);
    check("midrst_r31wr", {31'd0, bus.R31Wr}, 32'd0);
    check("midrst_r31", {2'd0, bus.R31}, 32'd0);
    check("midrst_valid", {31'd0, bus.wb_Valid}, 32'd0);
    tick();
    check("held_rst_wren", {31'd0, bus.WrEn}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    drive(1, 1, 5'd8, 0, LT_LW, 32'h5, 32'hFFFF_FFFF, 0, 30'd0);
    tick();
    check("alu_wren", {31'd0, bus.WrEn}, 32'd1);
    check("alu_rw", {27'd0, bus.Rw}, 32'd8);
    check("alu_busw", bus.busW, 32'h0000_0005);

    load_check("lb_off0", LT_LB, 32'h100, 32'hFFFF_FF80);
    load_check("lbu_off0", LT_LBU, 32'h100, 32'h0000_0080);
    load_check("lb_off2", LT_LB, 32'h102, 32'h0000_007F);
    load_check("lb_off1", LT_LB, 32'h101, 32'hFFFF_FFFF);
    load_check("lbu_off3", LT_LBU, 32'h103, 32'h0000_0001);
    load_check("lh_a1", LT_LH, 32'h102, 32'h0000_7F01);
    load_check("lh_a0_odd", LT_LH, 32'h101, 32'hFFFF_80FF);
    load_check("lhu_a0", LT_LHU, 32'h100, 32'h0000_80FF);
    load_check("lw", LT_LW, 32'h103, 32'h80FF_7F01);
    load_check("lt_rsvd", 3'd6, 32'h101, 32'h80FF_7F01);

    drive(1, 1, 5'd31, 0, LT_LW, 32'h44, 32'h0, 1, 30'h0000_0C01);
    tick();
    check("link_r31wr", {31'd0, bus.R31Wr}, 32'd1);
    check("link_r31", {2'd0, bus.R31}, 32'h0000_0C01);
    check("link_wren", {31'd0, bus.WrEn}, 32'd0);

    drive(1, 1, 5'd31, 0, LT_LW, 32'h44, 32'h0, 0, 30'd0);
    tick();
    check("r31_gpr_wren", {31'd0, bus.WrEn}, 32'd1);

    drive(1, 1, 5'd0, 0, LT_LW, 32'hDEAD_BEEF, 32'h0, 0, 30'd0);
    tick();
    check("r0_wren", {31'd0, bus.WrEn}, 32'd0);
    check("r0_busw", bus.busW, 32'hDEAD_BEEF);

    drive(1, 1, 5'd9, 0, LT_LW, 32'h1234, 32'h0, 0, 30'd0);
    tick();
    Stall = 1'b1;
    drive(1, 1, 5'd10, 0, LT_LW, 32'h9999, 32'h0, 1, 30'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rw", {27'd0, bus.Rw}, 32'd9);
      check("stall_busw", bus.busW, 32'h1234);
      check("stall_wren", {31'd0, bus.WrEn}, 32'd1);
      check("stall_r31wr", {31'd0, bus.R31Wr}, 32'd0);
    end
    Flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, bus.wb_Valid}, 32'd0);
    check("flush_wren", {31'd0, bus.WrEn}, 32'd0);
    check("flush_r31wr", {31'd0, bus.R31Wr}, 32'd0);
    check("flush_busw", bus.busW, 32'd0);

    Stall = 1'b0;
    Flush = 1'b0;
    drive(0, 1, 5'd5, 0, LT_LW, 32'h55, 32'h0, 1, 30'h3);
    tick();
    check("bubble_wren", {31'd0, bus.WrEn}, 32'd0);
    check("bubble_r31wr", {31'd0, bus.R31Wr}, 32'd0);
    check("bubble_valid", {31'd0, bus.wb_Valid}, 32'd0);
    check("bubble_rw", {27'd0, bus.Rw}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
